// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants, a clog2 helper and a parameter legality check.
package fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    // True when the parameter set describes a buildable FIFO.
    function automatic bit params_legal(input int unsigned dw, input int unsigned aw,
                                        input int unsigned afl, input int unsigned ael,
                                        input int unsigned mode);
        int unsigned depth;
        depth = 1 << aw;
        return (dw >= 1) && (aw >= 1) && (aw <= 16) && (clog2(depth) == aw) &&
               (afl >= 1) && (afl <= depth) && (ael <= depth - 1) &&
               ((mode == FIFO_MODE_STD) || (mode == FIFO_MODE_FWFT));
    endfunction

endpackage

// File: rtl/fifo_synchronous_thresh_if.sv
// Producer/consumer handshake, status and error bundle of the synchronous FIFO.
interface fifo_synchronous_thresh_if #(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 4
);
    logic                  write;
    logic [data_width-1:0] write_data;
    logic                  write_full;
    logic                  write_almost_full;
    logic                  read;
    logic [data_width-1:0] read_data;
    logic                  read_empty;
    logic                  read_almost_empty;
    logic [addr_width:0]   level;
    logic                  clear_errors;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write, write_data, read, clear_errors,
        input  write_full, write_almost_full, read_data, read_empty,
        input  read_almost_empty, level, overflow, underflow
    );

    modport slave (
        input  write, write_data, read, clear_errors,
        output write_full, write_almost_full, read_data, read_empty,
        output read_almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_ram #(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [addr_width-1:0] waddr_i,
    input  logic [data_width-1:0] wdata_i,
    input  logic [addr_width-1:0] raddr_i,
    output logic [data_width-1:0] rdata_o
);
    localparam int unsigned DEPTH = 1 << addr_width;

    logic [data_width-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/fifo_synchronous_thresh.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds, sticky errors
// and selectable registered or first-word-fall-through read.
module fifo_synchronous_thresh
    import fifo_pkg::*;
#(
    parameter int unsigned data_width         = 8,
    parameter int unsigned addr_width         = 4,
    parameter int unsigned almost_full_level  = 12,
    parameter int unsigned almost_empty_level = 2,
    parameter int unsigned fwft               = FIFO_MODE_STD
) (
    input logic                      clk,
    input logic                      rst_n,
    fifo_synchronous_thresh_if.slave bus
);
    localparam int unsigned DEPTH = 1 << addr_width;
    localparam int unsigned CNT_W = addr_width + 1;

    if (!params_legal(data_width, addr_width, almost_full_level, almost_empty_level, fwft)) begin : g_bad_params
        $error("fifo_synchronous_thresh: illegal parameter set");
    end

    logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
    logic                  empty_q, empty_d, full_q, full_d;
    logic                  afull_q, afull_d, aempty_q, aempty_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  read_accept, write_accept;
    logic [data_width-1:0] ram_rdata;

    // Acceptance uses only registered flags, so a full FIFO can still take a write alongside a pop.
    always_comb begin
        read_accept  = bus.read & ~empty_q;
        write_accept = bus.write & (~full_q | read_accept);
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (write_accept) wr_ptr_d = wr_ptr_q + CNT_W'(1);
        if (read_accept)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
        level_d  = level_q + CNT_W'(write_accept) - CNT_W'(read_accept);
        empty_d  = (level_d == '0);
        full_d   = (level_d == CNT_W'(DEPTH));
        afull_d  = (level_d >= CNT_W'(almost_full_level));
        aempty_d = (level_d <= CNT_W'(almost_empty_level));
        ovf_d    = (ovf_q & ~bus.clear_errors) | (bus.write & ~write_accept);
        unf_d    = (unf_q & ~bus.clear_errors) | (bus.read & empty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_ram #(
        .data_width (data_width),
        .addr_width (addr_width)
    ) u_ram (
        .clk     (clk),
        .we_i    (write_accept),
        .waddr_i (wr_ptr_q[addr_width-1:0]),
        .wdata_i (bus.write_data),
        .raddr_i (rd_ptr_q[addr_width-1:0]),
        .rdata_o (ram_rdata)
    );

    // FWFT exposes the head word directly; standard mode captures it on each pop.
    if (fwft == FIFO_MODE_FWFT) begin : g_fwft
        assign bus.read_data = empty_q ? '0 : ram_rdata;
    end else begin : g_std
        logic [data_width-1:0] rdata_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)           rdata_q <= '0;
            else if (read_accept) rdata_q <= ram_rdata;
        end
        assign bus.read_data = rdata_q;
    end

    assign bus.write_full        = full_q;
    assign bus.write_almost_full = afull_q;
    assign bus.read_empty        = empty_q;
    assign bus.read_almost_empty = aempty_q;
    assign bus.level             = level_q;
    assign bus.overflow          = ovf_q;
    assign bus.underflow         = unf_q;
endmodule

// File: tb/tb_fifo_synchronous_thresh.sv
// Drives a standard and an FWFT FIFO with identical stimulus and checks both against a queue model.
module tb_fifo_synchronous_thresh;
    import fifo_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFL   = 12;
    localparam int unsigned AEL   = 2;

    logic clk;
    logic rst_n;

    fifo_synchronous_thresh_if #(.data_width(8), .addr_width(4)) bus_s ();
    fifo_synchronous_thresh_if #(.data_width(8), .addr_width(4)) bus_f ();

    fifo_synchronous_thresh #(
        .data_width(8), .addr_width(4), .almost_full_level(AFL),
        .almost_empty_level(AEL), .fwft(FIFO_MODE_STD)
    ) u_dut_std (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    fifo_synchronous_thresh #(
        .data_width(8), .addr_width(4), .almost_full_level(AFL),
        .almost_empty_level(AEL), .fwft(FIFO_MODE_FWFT)
    ) u_dut_fwft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f)
    );

    logic [7:0] mq [$];
    bit         m_ovf;
    bit         m_unf;
    logic [7:0] m_rd;
    int         checks_total;
    int         checks_passed;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit c);
        bus_s.write = w; bus_s.write_data = d; bus_s.read = r; bus_s.clear_errors = c;
        bus_f.write = w; bus_f.write_data = d; bus_f.read = r; bus_f.clear_errors = c;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rd  = 8'h00;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, " s.level"}, 32'(bus_s.level), 32'd0);
        check_eq({tag, " s.empty"}, 32'(bus_s.read_empty), 32'd1);
        check_eq({tag, " s.aempty"}, 32'(bus_s.read_almost_empty), 32'd1);
        check_eq({tag, " s.full"}, 32'(bus_s.write_full), 32'd0);
        check_eq({tag, " s.afull"}, 32'(bus_s.write_almost_full), 32'd0);
        check_eq({tag, " s.ovf"}, 32'(bus_s.overflow), 32'd0);
        check_eq({tag, " s.unf"}, 32'(bus_s.underflow), 32'd0);
        check_eq({tag, " s.rdata"}, 32'(bus_s.read_data), 32'd0);
        check_eq({tag, " f.level"}, 32'(bus_f.level), 32'd0);
        check_eq({tag, " f.empty"}, 32'(bus_f.read_empty), 32'd1);
        check_eq({tag, " f.ovf"}, 32'(bus_f.overflow), 32'd0);
        check_eq({tag, " f.rdata"}, 32'(bus_f.read_data), 32'd0);
    endtask

    task automatic check_state(input string tag);
        int n;
        n = mq.size();
        check_eq({tag, " s.level"}, 32'(bus_s.level), 32'(n));
        check_eq({tag, " s.empty"}, 32'(bus_s.read_empty), 32'(n == 0));
        check_eq({tag, " s.full"}, 32'(bus_s.write_full), 32'(n == DEPTH));
        check_eq({tag, " s.afull"}, 32'(bus_s.write_almost_full), 32'(n >= AFL));
        check_eq({tag, " s.aempty"}, 32'(bus_s.read_almost_empty), 32'(n <= AEL));
        check_eq({tag, " s.ovf"}, 32'(bus_s.overflow), 32'(m_ovf));
        check_eq({tag, " s.unf"}, 32'(bus_s.underflow), 32'(m_unf));
        check_eq({tag, " s.rdata"}, 32'(bus_s.read_data), 32'(m_rd));
        check_eq({tag, " f.level"}, 32'(bus_f.level), 32'(n));
        check_eq({tag, " f.empty"}, 32'(bus_f.read_empty), 32'(n == 0));
        check_eq({tag, " f.full"}, 32'(bus_f.write_full), 32'(n == DEPTH));
        check_eq({tag, " f.ovf"}, 32'(bus_f.overflow), 32'(m_ovf));
        check_eq({tag, " f.unf"}, 32'(bus_f.underflow), 32'(m_unf));
        if (n > 0) check_eq({tag, " f.rdata"}, 32'(bus_f.read_data), 32'(mq[0]));
    endtask

    // One clock of stimulus; the model applies the FIFO rules to its queue before the edge.
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c, input string tag);
        bit empty, full, ra, wa;
        drive(w, d, r, c);
        empty = (mq.size() == 0);
        full  = (mq.size() == DEPTH);
        ra    = r && !empty;
        wa    = w && (!full || ra);
        if (ra) m_rd = mq.pop_front();
        if (wa) mq.push_back(d);
        m_ovf = (m_ovf && !c) || (w && !wa);
        m_unf = (m_unf && !c) || (r && empty);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        model_reset();
        #12;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, $sformatf("fill%0d", i));
        step(1'b1, 8'h11, 1'b0, 1'b0, "overflow");
        step(1'b0, 8'h00, 1'b0, 1'b1, "clear_ovf");
        step(1'b1, 8'hAA, 1'b1, 1'b0, "full_rw");
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, $sformatf("drain%0d", i));
        step(1'b1, 8'h55, 1'b1, 1'b0, "underflow");
        step(1'b0, 8'h00, 1'b1, 1'b0, "read_55");
        step(1'b0, 8'h00, 1'b1, 1'b1, "clear_vs_set");
        step(1'b0, 8'h00, 1'b0, 1'b1, "clear_unf");
        step(1'b1, 8'h3C, 1'b0, 1'b0, "fwft_write");
        step(1'b0, 8'h00, 1'b1, 1'b0, "fwft_pop");

        for (int i = 0; i < 400; i++) begin
            int wb;
            wb = (i < 200) ? 70 : 30;
            step(($urandom_range(0, 99) < wb), 8'($urandom), ($urandom_range(0, 99) < (100 - wb)),
                 ($urandom_range(0, 99) < 5), "random");
        end

        for (int i = 0; i < 20 && mq.size() > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "predrain");
        for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, "lvl7");
        check_eq("lvl7 level", 32'(bus_s.level), 32'd7);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0, $sformatf("wrap_w%0d", i));
            step(1'b0, 8'h00, 1'b1, 1'b0, $sformatf("wrap_r%0d", i));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
